// File: rtl/clk_div_gen.sv
// Programmable clock divider with registered CLKOUT/TICK, run/drain control
// and divisor changes deferred to period boundaries.
module clk_div_gen #(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [WIDTH-1:0] DIV_IN,
    input  logic             DIV_LOAD,
    output logic             CLKOUT,
    output logic             TICK,
    output logic             RUNNING,
    output logic             DIV_BUSY,
    output logic             DIV_ERR
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

    state_t           r_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_pdiv;
    logic             r_pend;
    logic             r_clkout;
    logic             r_tick;
    logic             r_err;

    state_t           w_state;
    logic [WIDTH-1:0] w_cnt;
    logic [WIDTH-1:0] w_div;
    logic [WIDTH-1:0] w_pdiv;
    logic             w_pend;
    logic             w_clkout;
    logic             w_tick;
    logic             w_err;
    logic             w_bnd;
    logic             w_good;
    logic             w_bad;

    assign w_good = DIV_LOAD && (DIV_IN >= TWO);
    assign w_bad  = DIV_LOAD && (DIV_IN < TWO);
    assign w_bnd  = (r_state != S_IDLE) && (r_cnt == r_div - ONE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_div    <= DEF;
            r_pdiv   <= DEF;
            r_pend   <= 1'b0;
            r_clkout <= 1'b0;
            r_tick   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_div    <= w_div;
            r_pdiv   <= w_pdiv;
            r_pend   <= w_pend;
            r_clkout <= w_clkout;
            r_tick   <= w_tick;
            r_err    <= w_err;
        end
    end

    always_comb begin
        w_state = r_state;
        unique case (r_state)
            S_IDLE:  if (EN) w_state = S_RUN;
            S_RUN:   if (!EN) w_state = S_DRAIN;
            S_DRAIN: begin
                if (EN)         w_state = S_RUN;
                else if (w_bnd) w_state = S_IDLE;
            end
            default: w_state = S_IDLE;
        endcase
    end

    // Divisor only ever changes in IDLE or on a wrap edge, never mid-period.
    always_comb begin
        w_div  = r_div;
        w_pdiv = r_pdiv;
        w_pend = r_pend;
        if (r_state == S_IDLE || w_bnd) begin
            if (w_good) begin
                w_div  = DIV_IN;
                w_pdiv = DIV_IN;
            end else if (r_pend) begin
                w_div  = r_pdiv;
            end
            w_pend = 1'b0;
        end else if (w_good) begin
            w_pdiv = DIV_IN;
            w_pend = 1'b1;
        end
        if (w_state == S_IDLE || r_state == S_IDLE || w_bnd)
            w_cnt = '0;
        else
            w_cnt = r_cnt + ONE;
    end

    // Outputs are decoded from next-cycle values so the flops line up with cnt.
    always_comb begin
        w_clkout = (w_state != S_IDLE) && (w_cnt < (w_div >> 1));
        w_tick   = (w_state != S_IDLE) && (w_cnt == w_div - ONE);
        w_err    = w_bad;
    end

    assign CLKOUT   = r_clkout;
    assign TICK     = r_tick;
    assign RUNNING  = (r_state != S_IDLE);
    assign DIV_BUSY = r_pend;
    assign DIV_ERR  = r_err;

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen: directed scenarios plus random
// traffic against a period-level reference model.
module tb_clk_div_gen;

    localparam int W = 6;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         EN = 1'b0;
    logic [W-1:0] DIV_IN = '0;
    logic         DIV_LOAD = 1'b0;
    logic         CLKOUT, TICK, RUNNING, DIV_BUSY, DIV_ERR;

    clk_div_gen #(.WIDTH(W), .DEFAULT_DIV(2)) dut (
        .CLK(CLK), .RST(RST), .EN(EN),
        .DIV_IN(DIV_IN), .DIV_LOAD(DIV_LOAD),
        .CLKOUT(CLKOUT), .TICK(TICK), .RUNNING(RUNNING),
        .DIV_BUSY(DIV_BUSY), .DIV_ERR(DIV_ERR)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0, n_err = 0, cyc = 0;
    int last_tick = -1, last_gap = 0, n_busy = 0, n_tick = 0, n_idle = 0;

    // model: 0 idle, 1 run, 2 drain; pos = position within the period
    int m_st = 0, m_pos = 0, m_div = 2, m_pdiv = 2;
    bit m_pend = 0, m_err = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model();
        int d, nst;
        bit good, wrap;
        if (RST) begin
            m_st = 0; m_pos = 0; m_div = 2; m_pdiv = 2;
            m_pend = 0; m_err = 0;
        end else begin
            d = int'(DIV_IN);
            good = DIV_LOAD && d >= 2;
            wrap = m_st != 0 && m_pos == m_div - 1;
            m_err = DIV_LOAD && d < 2;
            nst = m_st;
            if (m_st == 0) nst = EN ? 1 : 0;
            else if (EN) nst = 1;
            else if (m_st == 1) nst = 2;
            else if (wrap) nst = 0;
            if (m_st == 0 || wrap) begin
                if (good) m_div = d;
                else if (m_pend) m_div = m_pdiv;
                m_pend = 0;
            end else if (good) begin
                m_pdiv = d;
                m_pend = 1;
            end
            m_pos = (nst == 0 || m_st == 0 || wrap) ? 0 : m_pos + 1;
            m_st = nst;
        end
    endtask

    task automatic step();
        int run, e;
        @(posedge CLK);
        model();
        #1;
        cyc++;
        run = (m_st != 0) ? 1 : 0;
        e = {run != 0 && m_pos < m_div / 2,
             run != 0 && m_pos == m_div - 1,
             run != 0, m_pend, m_err};
        check($sformatf("outs@%0d", cyc),
              {CLKOUT, TICK, RUNNING, DIV_BUSY, DIV_ERR}, e);
        if (TICK) begin
            n_tick++;
            if (last_tick >= 0) last_gap = cyc - last_tick;
            last_tick = cyc;
        end
        if (DIV_BUSY) n_busy++;
        if (!RUNNING) n_idle++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load(input int v);
        DIV_IN = W'(v);
        DIV_LOAD = 1'b1;
        step();
        DIV_LOAD = 1'b0;
    endtask

    task automatic wait_pos(input int p);
        for (int i = 0; i < 300; i++) begin
            if (m_st != 0 && m_pos == p) return;
            step();
        end
        check("wait_pos_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (!RUNNING) return;
            step();
        end
        check("wait_idle_timeout", 0, 1);
    endtask

    initial begin
        steps(2);
        check("reset_outs", {CLKOUT, TICK, RUNNING, DIV_BUSY, DIV_ERR}, 0);
        RST = 1'b0;

        EN = 1'b1;
        steps(9);
        check("div2_gap", last_gap, 2);

        EN = 1'b0;
        wait_idle();
        load(5);
        EN = 1'b1;
        steps(16);
        check("div5_gap", last_gap, 5);
        load(1);
        check("err_pulse", DIV_ERR, 1);
        steps(12);
        check("div5_kept", last_gap, 5);

        load(4);
        wait_pos(0);
        n_busy = 0;
        load(6);
        steps(16);
        check("busy_len", n_busy, 3);
        check("div6_gap", last_gap, 6);

        load(4);
        wait_pos(0);
        steps(1);
        wait_pos(0);
        load(8);
        load(10);
        steps(25);
        check("last_load_wins", last_gap, 10);

        load(4);
        wait_pos(0);
        steps(1);
        wait_pos(3);
        n_busy = 0;
        load(7);
        steps(16);
        check("bnd_load_busy", n_busy, 0);
        check("div7_gap", last_gap, 7);

        load(6);
        wait_pos(0);
        steps(1);
        wait_pos(2);
        EN = 1'b0;
        n_tick = 0;
        step();
        wait_idle();
        check("drain_ticks", n_tick, 1);
        check("drain_clkout", CLKOUT, 0);
        EN = 1'b1;
        steps(2);
        wait_pos(1);
        EN = 1'b0;
        step();
        wait_pos(4);
        EN = 1'b1;
        n_idle = 0;
        steps(20);
        check("no_gap", n_idle, 0);
        check("resume_gap", last_gap, 6);

        load(8);
        wait_pos(0);
        steps(1);
        wait_pos(1);
        load(5);
        check("pend_busy", DIV_BUSY, 1);
        wait_pos(3);
        RST = 1'b1;
        n_tick = 0;
        step();
        RST = 1'b0;
        check("rst_abort", {CLKOUT, TICK, RUNNING, DIV_BUSY, DIV_ERR}, 0);
        check("rst_no_tick", n_tick, 0);
        steps(8);
        check("rst_default_div", last_gap, 2);

        load(63);
        steps(140);
        check("div63_gap", last_gap, 63);

        for (int i = 0; i < 600; i++) begin
            RST = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 19) == 0) EN = ~EN;
            DIV_LOAD = ($urandom_range(0, 7) == 0);
            DIV_IN = ($urandom_range(0, 3) == 0) ?
                     W'($urandom_range(0, 63)) : W'($urandom_range(0, 9));
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
